// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - frames UART bytes into SYNC/ADDR/DATA/CHK packets and issues register writes
// Also owns the uart_rx baud divisor, updated in-band through addresses FE/FF.
module uart_cmd_ctrl #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter logic [10:0] DIV_RST     = 11'h016,
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [10:0] div_o,
  input  logic        rx_done_i,
  input  logic [7:0]  rx_data_i,
  output logic        wr_valid_o,
  input  logic        wr_ready_i,
  output logic [7:0]  wr_addr_o,
  output logic [7:0]  wr_data_o,
  output logic        err_chk_o,
  output logic        err_tmo_o,
  output logic        err_ovr_o,
  output logic [7:0]  err_cnt_o,
  output logic        busy_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, CHK, WR} state_t;

  state_t        state_q, state_d;
  logic [7:0]    addr_q, addr_d, data_q, data_d;
  logic [7:0]    wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [10:0]   div_q, div_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic          wr_valid_q, wr_valid_d;
  logic          err_chk_q, err_chk_d, err_tmo_q, err_tmo_d, err_ovr_q, err_ovr_d;
  logic          busy_q, busy_d;
  logic [7:0]    chk_sum;

  assign chk_sum = addr_q + data_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    div_d      = div_q;
    tmo_d      = tmo_q;
    wr_valid_d = wr_valid_q;
    err_chk_d  = 1'b0;
    err_tmo_d  = 1'b0;
    err_ovr_d  = 1'b0;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (rx_done_i && rx_data_i == SYNC_BYTE) state_d = ADDR;
      end
      ADDR, DATA, CHK: begin
        // A byte arriving in the expiry cycle takes priority over the timeout.
        if (rx_done_i) begin
          tmo_d = '0;
          case (state_q)
            ADDR: begin addr_d = rx_data_i; state_d = DATA; end
            DATA: begin data_d = rx_data_i; state_d = CHK; end
            default: begin
              state_d = IDLE;
              if (rx_data_i != chk_sum) begin
                err_chk_d = 1'b1;
              end else if (addr_q == 8'hFE) begin
                div_d[7:0] = data_q;
              end else if (addr_q == 8'hFF) begin
                div_d[10:8] = data_q[2:0];
              end else begin
                wr_valid_d = 1'b1;
                wr_addr_d  = addr_q;
                wr_data_d  = data_q;
                state_d    = WR;
              end
            end
          endcase
        end else if (tmo_q == TMO_LAST) begin
          tmo_d     = '0;
          err_tmo_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WR: begin
        if (rx_done_i) err_ovr_d = 1'b1;
        if (wr_ready_i) begin
          wr_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if ((err_chk_d || err_tmo_d || err_ovr_d) && err_cnt_q != 8'hFF)
      err_cnt_d = err_cnt_q + 8'd1;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= 8'h00;
      data_q     <= 8'h00;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 8'h00;
      div_q      <= DIV_RST;
      tmo_q      <= '0;
      wr_valid_q <= 1'b0;
      err_chk_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
      err_ovr_q  <= 1'b0;
      err_cnt_q  <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      div_q      <= div_d;
      tmo_q      <= tmo_d;
      wr_valid_q <= wr_valid_d;
      err_chk_q  <= err_chk_d;
      err_tmo_q  <= err_tmo_d;
      err_ovr_q  <= err_ovr_d;
      err_cnt_q  <= err_cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign div_o      = div_q;
  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign err_chk_o  = err_chk_q;
  assign err_tmo_o  = err_tmo_q;
  assign err_ovr_o  = err_ovr_q;
  assign err_cnt_o  = err_cnt_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - self-checking bench for uart_cmd_ctrl
module tb_uart_cmd_ctrl;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] div;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_addr, wr_data;
  logic        err_chk, err_tmo, err_ovr;
  logic [7:0]  err_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int exp_errs = 0;
  logic [15:0] sb_q[$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  d;
    logic [7:0]  c;
    logic        exp_wr;
    logic        exp_chk;
    logic [10:0] exp_div;
  } vec_t;

  uart_cmd_ctrl #(.SYNC_BYTE(8'hA5), .DIV_RST(11'h016), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .div_o(div), .rx_done_i(rx_done), .rx_data_i(rx_data),
    .wr_valid_o(wr_valid), .wr_ready_i(wr_ready), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .err_chk_o(err_chk), .err_tmo_o(err_tmo), .err_ovr_o(err_ovr), .err_cnt_o(err_cnt),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Handshake monitor: every accepted write must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && wr_valid && wr_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_write", {wr_addr, wr_data}, 16'hxxxx);
      end else begin
        chk("wr_addr_data", {wr_addr, wr_data}, sb_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_done = 1'b1;
    rx_data = b;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(d);
    send_byte(c);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, sb_q.size(), 0);
  endtask

  initial begin
    vec_t vecs[10];
    int n;
    vecs[0] = '{8'h10, 8'h3C, 8'h4C, 1'b1, 1'b0, 11'h016};
    vecs[1] = '{8'h10, 8'h3C, 8'h00, 1'b0, 1'b1, 11'h016};
    vecs[2] = '{8'hFE, 8'h40, 8'h3E, 1'b0, 1'b0, 11'h040};
    vecs[3] = '{8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 11'h140};
    vecs[4] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b0, 11'h140};
    vecs[5] = '{8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 11'h140};
    vecs[6] = '{8'hFD, 8'hFF, 8'hFC, 1'b1, 1'b0, 11'h140};
    vecs[7] = '{8'hFE, 8'h16, 8'h14, 1'b0, 1'b0, 11'h116};
    vecs[8] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, 11'h016};
    vecs[9] = '{8'h20, 8'h55, 8'h00, 1'b0, 1'b1, 11'h016};

    rst = 1'b1; rx_done = 1'b0; rx_data = 8'h00; wr_ready = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_div", div, 11'h016);
    chk("rst_valid", wr_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err_cnt", err_cnt, 8'h00);
    chk("rst_addr_data", {wr_addr, wr_data}, 16'h0000);
    chk("rst_pulses", {err_chk, err_tmo, err_ovr}, 3'b000);

    send_byte(8'h00);
    send_byte(8'hFF);
    chk("junk_busy", busy, 1'b0);
    chk("junk_err_cnt", err_cnt, 8'h00);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].exp_wr) sb_q.push_back({vecs[i].a, vecs[i].d});
      if (vecs[i].exp_chk) exp_errs++;
      send_pkt(vecs[i].a, vecs[i].d, vecs[i].c);
      chk($sformatf("v%0d_valid", i), wr_valid, vecs[i].exp_wr);
      chk($sformatf("v%0d_err_chk", i), err_chk, vecs[i].exp_chk);
      chk($sformatf("v%0d_div", i), div, vecs[i].exp_div);
      tick(3);
      chk($sformatf("v%0d_idle", i), {busy, wr_valid, err_chk}, 3'b000);
      chk($sformatf("v%0d_err_cnt", i), err_cnt, exp_errs);
    end
    wait_drain("table_drain");

    // Timeout after ADDR byte: pulse exactly TMO cycles after the last strobe.
    send_byte(8'hA5);
    send_byte(8'h10);
    n = 0;
    while (!err_tmo && n < TMO + 10) begin
      @(posedge clk); #1;
      n++;
    end
    exp_errs++;
    chk("tmo_latency", n, TMO);
    chk("tmo_busy", busy, 1'b0);
    chk("tmo_err_cnt", err_cnt, exp_errs);

    // Strobe landing in the expiry cycle wins over the timeout.
    sb_q.push_back(16'h103C);
    send_byte(8'hA5);
    send_byte(8'h10);
    tick(TMO - 2);
    send_byte(8'h3C);
    chk("expiry_no_tmo", err_tmo, 1'b0);
    chk("expiry_busy", busy, 1'b1);
    send_byte(8'h4C);
    chk("expiry_valid", wr_valid, 1'b1);
    wait_drain("expiry_drain");

    // Write held off by the consumer; bytes arriving meanwhile are dropped.
    wr_ready = 1'b0;
    sb_q.push_back(16'h103C);
    send_pkt(8'h10, 8'h3C, 8'h4C);
    chk("hold_valid", wr_valid, 1'b1);
    tick(20);
    send_byte(8'h55);
    exp_errs++;
    chk("ovr_pulse", err_ovr, 1'b1);
    chk("ovr_hold", {wr_valid, wr_addr, wr_data}, {1'b1, 16'h103C});
    send_byte(8'hA5);
    exp_errs++;
    chk("ovr_sync_pulse", err_ovr, 1'b1);
    tick(1);
    chk("ovr_one_cycle", err_ovr, 1'b0);
    tick(24);
    chk("ovr_err_cnt", err_cnt, exp_errs);
    wr_ready = 1'b1;
    wait_drain("ovr_drain");
    tick(1);
    chk("ovr_idle", {busy, wr_valid}, 2'b00);

    // Reset mid-packet restores divisor and state.
    send_pkt(8'hFE, 8'h40, 8'h3E);
    chk("pre_rst_div", div, 11'h040);
    send_byte(8'hA5);
    send_byte(8'h10);
    do_reset();
    exp_errs = 0;
    chk("rst_pkt", {busy, div, err_cnt}, {1'b0, 11'h016, 8'h00});

    // Reset while a write is pending drops wr_valid.
    wr_ready = 1'b0;
    send_pkt(8'h30, 8'h11, 8'h41);
    chk("pend_valid", wr_valid, 1'b1);
    do_reset();
    chk("rst_wr", {wr_valid, busy, wr_addr, wr_data}, 18'h0);

    // Error counter saturates under a long burst of dropped bytes.
    sb_q.push_back(16'h3011);
    send_pkt(8'h30, 8'h11, 8'h41);
    @(posedge clk); #1;
    for (int i = 0; i < 260; i++) begin
      rx_done = 1'b1;
      rx_data = 8'(i);
      @(posedge clk); #1;
    end
    rx_done = 1'b0;
    tick(1);
    chk("err_cnt_sat", err_cnt, 8'hFF);
    wr_ready = 1'b1;
    wait_drain("sat_drain");
    tick(2);
    chk("end_idle", {busy, wr_valid}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
